coef_stream_loader: RTL

//  Receives coefficients serially on a valid/ready stream with tlast framing and presents them as a

---
 rtl/coef_stream_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/coef_stream_loader.sv
// Serial-to-parallel coefficient loader: a tlast-framed stream fills a shadow bank.
// The active bank c[] is replaced in one edge when exactly NC words arrive.
module coef_stream_loader #(
    parameter int COEFW = 18,
    parameter int NC    = 6,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COEFW-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [COEFW-1:0] c [NC],
    output logic             c_valid,
    output logic             c_update,
    output logic             err,
    output logic [ERRW-1:0]  err_count
);

    localparam int IDXW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NC - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    logic [1:0]      state_reg;
    logic [IDXW-1:0] idx_reg;
    logic            c_valid_reg;
    logic            c_update_reg;
    logic            err_reg;
    logic [ERRW-1:0] err_count_reg;
    logic [ERRW-1:0] err_count_next;
    logic            beat;
    logic            load_beat;
    logic            at_last;

    // Ready comes only from registered state and reset, never from s_tvalid.
    assign s_tready  = rst_n && (state_reg != ST_COMMIT);
    assign beat      = s_tvalid && s_tready;
    assign load_beat = beat && (state_reg == ST_LOAD);
    assign at_last   = (idx_reg == LAST_IDX);

    assign err_count_next = (err_count_reg == ERR_MAX) ? err_count_reg
                                                       : err_count_reg + ERRW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_LOAD;
            idx_reg       <= '0;
            c_valid_reg   <= 1'b0;
            c_update_reg  <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            c_update_reg <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (beat) begin
                        if (at_last) begin
                            idx_reg <= '0;
                            if (s_tlast) begin
                                state_reg <= ST_COMMIT;
                            end else begin
                                // Too many words: flag now, swallow the rest of the frame.
                                err_reg       <= 1'b1;
                                err_count_reg <= err_count_next;
                                state_reg     <= ST_DISCARD;
                            end
                        end else if (s_tlast) begin
                            err_reg       <= 1'b1;
                            err_count_reg <= err_count_next;
                            idx_reg       <= '0;
                        end else begin
                            idx_reg <= idx_reg + IDXW'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (beat && s_tlast) begin
                        state_reg <= ST_LOAD;
                        idx_reg   <= '0;
                    end
                end
                ST_COMMIT: begin
                    c_update_reg <= 1'b1;
                    c_valid_reg  <= 1'b1;
                    idx_reg      <= '0;
                    state_reg    <= ST_LOAD;
                end
                default: begin
                    state_reg <= ST_LOAD;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_coef
            logic [COEFW-1:0] sh_reg;
            logic [COEFW-1:0] c_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sh_reg <= '0;
                    c_reg  <= '0;
                end else begin
                    if (load_beat && (idx_reg == IDXW'(gi)))
                        sh_reg <= s_tdata;
                    if (state_reg == ST_COMMIT)
                        c_reg <= sh_reg;
                end
            end

            assign c[gi] = c_reg;
        end
    endgenerate

    assign c_valid   = c_valid_reg;
    assign c_update  = c_update_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;

endmodule
